unidad_control_multiciclo: RTL and testbench
============================================

Name: unidad_control_multiciclo

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. A Moore FSM sequences each instruction over 3–5 cycles (fetch, decode, execute, memory, write-back) and drives datapath strobes per state. Memory accesses use a ready handshake with an optional wait timeout. Adds ADDI support, a retired-instruction counter and sticky error flags. Sits between the instruction register opcode field and the shared multi-cycle datapath.

Parameters:
ANCHO_CONT, 16, width of retired-instruction counter
MAX_ESPERA, 8, max cycles waiting on mem_listo before abort; 0 = no timeout
HABILITAR_ADDI, 1, 1 = opcode 6'b001000 (ADDI) decoded; 0 = treated as invalid

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
codigo_operacion  input  6  opcode from instruction register (valid from DECODE onward)
mem_listo  input  1  memory completed requested read/write this cycle
pc_escribir  output  1  unconditional PC write
pc_escribir_cond  output  1  PC write if ALU zero (BEQ)
iord  output  1  memory address select: 0 = PC, 1 = ALU out
mem_leer  output  1  memory read request
mem_escribir  output  1  memory write request
ir_escribir  output  1  load instruction register
mem_a_reg  output  1  write-back source: 1 = memory data
destino_reg  output  1  destination register: 1 = rd, 0 = rt
reg_escribir  output  1  register file write
alu_fuente_a  output  1  0 = PC, 1 = register A
alu_fuente_b  output  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_operacion  output  2  00 add, 01 sub, 10 funct-decoded
fuente_pc  output  2  00 = ALU, 01 = ALU out (branch target), 10 = jump target
estado  output  4  current state encoding (debug)
instr_terminada  output  1  one-cycle pulse on instruction retire
contador_instr  output  ANCHO_CONT  retired instructions, saturating
op_invalida  output  1  sticky: unrecognised opcode decoded
error_memoria  output  1  sticky: mem_listo timeout

Behaviour:
- Reset (async): estado = FETCH (0), wait counter = 0, contador_instr = 0, op_invalida = 0, error_memoria = 0. While reset is high, all strobes (pc_escribir, pc_escribir_cond, ir_escribir, reg_escribir, mem_escribir, mem_leer) and instr_terminada = 0. Mux selects take their FETCH values.
- Outputs are a Moore decode of estado. Exceptions:
  - pc_escribir and ir_escribir in FETCH are ANDed with mem_listo.
  - instr_terminada in MEM_WRITE is ANDed with mem_listo.
- States (encoding), unlisted outputs 0:
  - FETCH(0): mem_leer=1, iord=0, alu_a=0, alu_b=01, op=00, fuente_pc=00. mem_listo → DECODE, else stay.
  - DECODE(1): alu_a=0, alu_b=11, op=00. Next state by opcode:
    - 100011 or 101011 → MEM_ADDR
    - 000000 → R_EXEC
    - 000100 → BEQ
    - 000010 → JUMP
    - 001000 with HABILITAR_ADDI=1 → ADDI_EXEC
    - else: set op_invalida, → FETCH, no retire.
  - MEM_ADDR(2): alu_a=1, alu_b=10, op=00. LW → MEM_READ, SW → MEM_WRITE.
  - MEM_READ(3): mem_leer=1, iord=1. mem_listo → MEM_WB.
  - MEM_WB(4): reg_escribir=1, mem_a_reg=1, destino_reg=0; retire; → FETCH.
  - MEM_WRITE(5): mem_escribir=1, iord=1. mem_listo → retire, → FETCH.
  - R_EXEC(6): alu_a=1, alu_b=00, op=10 → R_WB.
  - R_WB(7): reg_escribir=1, destino_reg=1, mem_a_reg=0; retire; → FETCH.
  - BEQ(8): alu_a=1, alu_b=00, op=01, pc_escribir_cond=1, fuente_pc=01; retire; → FETCH.
  - JUMP(9): pc_escribir=1, fuente_pc=10; retire; → FETCH.
  - ADDI_EXEC(10): alu_a=1, alu_b=10, op=00 → ADDI_WB.
  - ADDI_WB(11): reg_escribir=1, destino_reg=0, mem_a_reg=0; retire; → FETCH.
  - Encodings 12–15: all outputs 0, → FETCH.
- Latencies with mem_listo always 1: R/ADDI = 4 cycles, LW = 5, SW = 4, BEQ/J = 3.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with mem_listo=0. Clears on state change or mem_listo=1.
  - When MAX_ESPERA≠0 and counter reaches MAX_ESPERA with mem_listo still 0: set error_memoria, → FETCH next cycle, no strobes that cycle, no retire.
  - A timeout in FETCH re-enters FETCH with a cleared counter.
- Retire: instr_terminada=1 for exactly one cycle. contador_instr += 1 on that cycle, holding at 2^ANCHO_CONT−1 (no wrap).
- mem_listo in non-memory states is ignored.
- Sticky flags clear only on reset.
- Reset asserted mid-instruction aborts immediately; there is no partial write-back afterwards.

Decomposition:
- Shared package holds:
  - opcode constants: OP_TIPO_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - state encoding constants (4-bit)
  - alu_fuente_b, alu_operacion and fuente_pc select constants
- FSM, wait counter and output decode stay in one module.
- Natural sub-module: contador_saturado (parametrised width, increment enable, async reset), used for contador_instr.

Test Plan:
- R-type (op 000000), mem_listo=1 → estado 0,1,6,7,0. R_WB has reg_escribir=1, destino_reg=1. One instr_terminada pulse; contador_instr=1.
- LW (100011) with mem_listo low 2 cycles in MEM_READ, MAX_ESPERA=8 → estado 0,1,2,3,3,3,4,0. mem_a_reg=1 only in state 4. error_memoria stays 0.
- BEQ then J → BEQ asserts pc_escribir_cond=1, fuente_pc=01 for exactly one cycle. JUMP asserts pc_escribir=1, fuente_pc=10. contador_instr +2.
- Opcode 111111, then ADDI with HABILITAR_ADDI=0 → op_invalida=1 after first DECODE, returns to FETCH, contador_instr unchanged. Same ADDI with HABILITAR_ADDI=1 → states 10,11, reg_escribir=1, destino_reg=0.
- SW with mem_listo held 0, MAX_ESPERA=4 → after 4 wait cycles error_memoria=1, estado→0, mem_escribir never accompanied by retire. Reset mid-MEM_WRITE → immediate estado=0, all strobes 0, flags and counter cleared.
- ANCHO_CONT=2, 5 R-type instructions → contador_instr 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/unidad_control_multiciclo_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: opcodes, state
// encoding and datapath mux selects.
package unidad_control_multiciclo_pkg;

  localparam logic [5:0] OP_TIPO_R = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_ADDI   = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } estado_t;

  localparam logic [1:0] ALU_B_REG      = 2'b00;
  localparam logic [1:0] ALU_B_CUATRO   = 2'b01;
  localparam logic [1:0] ALU_B_INM      = 2'b10;
  localparam logic [1:0] ALU_B_INM_DESP = 2'b11;

  localparam logic [1:0] ALU_OP_SUMA  = 2'b00;
  localparam logic [1:0] ALU_OP_RESTA = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SALTO   = 2'b10;

  // States that wait on the memory ready handshake
  function automatic logic es_estado_memoria(input estado_t e);
    return (e == S_FETCH) || (e == S_MEM_READ) || (e == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/unidad_control_multiciclo_contador.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module contador_saturado #(
  parameter int ANCHO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitar,
  output logic [ANCHO-1:0] cuenta
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta <= '0;
    end else if (habilitar && (cuenta != '1)) begin
      cuenta <= cuenta + 1'b1;
    end
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back, memory ready timeout, retire counter and sticky errors.
//
// state       | meaning
// FETCH 0     | read instruction, PC += 4 when memory ready
// DECODE 1    | read registers, precompute branch target
// MEM_ADDR 2  | effective address for LW/SW
// MEM_READ 3  | data read;  MEM_WB 4 | load write-back
// MEM_WRITE 5 | data write, retires on ready
// R_EXEC 6    | R-type ALU;  R_WB 7 | R-type write-back
// BEQ 8       | compare and conditional PC write;  JUMP 9 | PC <- target
// ADDI_EXEC 10| immediate add;  ADDI_WB 11 | immediate write-back
module unidad_control_multiciclo
  import unidad_control_multiciclo_pkg::*;
#(
  parameter int ANCHO_CONT     = 16,
  parameter int MAX_ESPERA     = 8,
  parameter int HABILITAR_ADDI = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            codigo_operacion,
  input  logic                  mem_listo,
  output logic                  pc_escribir,
  output logic                  pc_escribir_cond,
  output logic                  iord,
  output logic                  mem_leer,
  output logic                  mem_escribir,
  output logic                  ir_escribir,
  output logic                  mem_a_reg,
  output logic                  destino_reg,
  output logic                  reg_escribir,
  output logic                  alu_fuente_a,
  output logic [1:0]            alu_fuente_b,
  output logic [1:0]            alu_operacion,
  output logic [1:0]            fuente_pc,
  output logic [3:0]            estado,
  output logic                  instr_terminada,
  output logic [ANCHO_CONT-1:0] contador_instr,
  output logic                  op_invalida,
  output logic                  error_memoria
);

  localparam int ANCHO_ESP = $clog2(MAX_ESPERA + 2);
  localparam logic [ANCHO_ESP-1:0] LIMITE_ESPERA = ANCHO_ESP'(MAX_ESPERA);

  estado_t              estado_q;
  logic [ANCHO_ESP-1:0] espera_q;
  logic                 esperando;
  logic                 timeout;

  assign esperando = es_estado_memoria(estado_q) && !mem_listo;
  assign timeout   = (MAX_ESPERA != 0) && esperando && (espera_q == LIMITE_ESPERA);
  assign estado    = estado_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q      <= S_FETCH;
      espera_q      <= '0;
      op_invalida   <= 1'b0;
      error_memoria <= 1'b0;
    end else begin
      // Counter saturates so MAX_ESPERA = 0 (no timeout) never wraps it
      if (esperando && !timeout) begin
        if (espera_q != '1) espera_q <= espera_q + 1'b1;
      end else begin
        espera_q <= '0;
      end

      if (timeout) begin
        error_memoria <= 1'b1;
        estado_q      <= S_FETCH;
      end else begin
        case (estado_q)
          S_FETCH:     if (mem_listo) estado_q <= S_DECODE;
          S_DECODE: begin
            case (codigo_operacion)
              OP_LW, OP_SW: estado_q <= S_MEM_ADDR;
              OP_TIPO_R:    estado_q <= S_R_EXEC;
              OP_BEQ:       estado_q <= S_BEQ;
              OP_J:         estado_q <= S_JUMP;
              OP_ADDI: begin
                if (HABILITAR_ADDI != 0) begin
                  estado_q <= S_ADDI_EXEC;
                end else begin
                  op_invalida <= 1'b1;
                  estado_q    <= S_FETCH;
                end
              end
              default: begin
                op_invalida <= 1'b1;
                estado_q    <= S_FETCH;
              end
            endcase
          end
          S_MEM_ADDR:  estado_q <= (codigo_operacion == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
          S_MEM_READ:  if (mem_listo) estado_q <= S_MEM_WB;
          S_MEM_WRITE: if (mem_listo) estado_q <= S_FETCH;
          S_R_EXEC:    estado_q <= S_R_WB;
          S_ADDI_EXEC: estado_q <= S_ADDI_WB;
          default:     estado_q <= S_FETCH;
        endcase
      end
    end
  end

  always_comb begin
    pc_escribir      = 1'b0;
    pc_escribir_cond = 1'b0;
    iord             = 1'b0;
    mem_leer         = 1'b0;
    mem_escribir     = 1'b0;
    ir_escribir      = 1'b0;
    mem_a_reg        = 1'b0;
    destino_reg      = 1'b0;
    reg_escribir     = 1'b0;
    alu_fuente_a     = 1'b0;
    alu_fuente_b     = ALU_B_REG;
    alu_operacion    = ALU_OP_SUMA;
    fuente_pc        = PC_ALU;
    instr_terminada  = 1'b0;
    case (estado_q)
      S_FETCH: begin
        mem_leer     = 1'b1;
        alu_fuente_b = ALU_B_CUATRO;
        pc_escribir  = mem_listo;
        ir_escribir  = mem_listo;
      end
      S_DECODE:    alu_fuente_b = ALU_B_INM_DESP;
      S_MEM_ADDR: begin
        alu_fuente_a = 1'b1;
        alu_fuente_b = ALU_B_INM;
      end
      S_MEM_READ: begin
        mem_leer = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_escribir    = 1'b1;
        mem_a_reg       = 1'b1;
        instr_terminada = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_escribir    = 1'b1;
        iord            = 1'b1;
        instr_terminada = mem_listo;
      end
      S_R_EXEC: begin
        alu_fuente_a  = 1'b1;
        alu_operacion = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        reg_escribir    = 1'b1;
        destino_reg     = 1'b1;
        instr_terminada = 1'b1;
      end
      S_BEQ: begin
        alu_fuente_a     = 1'b1;
        alu_operacion    = ALU_OP_RESTA;
        pc_escribir_cond = 1'b1;
        fuente_pc        = PC_ALU_OUT;
        instr_terminada  = 1'b1;
      end
      S_JUMP: begin
        pc_escribir     = 1'b1;
        fuente_pc       = PC_SALTO;
        instr_terminada = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_fuente_a = 1'b1;
        alu_fuente_b = ALU_B_INM;
      end
      S_ADDI_WB: begin
        reg_escribir    = 1'b1;
        instr_terminada = 1'b1;
      end
      default: ;
    endcase
    // Reset and the timeout cycle must never leak a write or a retire
    if (reset || timeout) begin
      pc_escribir      = 1'b0;
      pc_escribir_cond = 1'b0;
      mem_leer         = 1'b0;
      mem_escribir     = 1'b0;
      ir_escribir      = 1'b0;
      reg_escribir     = 1'b0;
      instr_terminada  = 1'b0;
    end
  end

  contador_saturado #(
    .ANCHO(ANCHO_CONT)
  ) u_contador (
    .clk      (clk),
    .reset    (reset),
    .habilitar(instr_terminada),
    .cuenta   (contador_instr)
  );

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Bench for unidad_control_multiciclo: two configurations driven by directed
// and random instruction streams, checked against an instruction-level model.
module tb_unidad_control_multiciclo;

  localparam logic [16:0] MASK_STROBES = 17'b1_1_0_1_1_1_0_0_1_0_00_00_00_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v;
  logic [1:0] listo_v;
  logic [5:0] opc [2];
  logic [5:0] next_op [2];

  wire [1:0]  pcw, pcwc, iord_w, mlw, mew, irw, m2r, dst, rgw, afa, ret, opi, emem;
  wire [1:0]  afb [2];
  wire [1:0]  aop [2];
  wire [1:0]  fpc [2];
  wire [3:0]  est [2];
  wire [15:0] cnt_a;
  wire [1:0]  cnt_b;

  int ncmp = 0;
  int nfail = 0;
  int max_w [2] = '{8, 4};
  int ancho [2] = '{16, 2};
  bit addi_en [2] = '{1'b1, 1'b0};
  int cnt_exp [2];
  bit inv_exp [2];
  bit err_exp [2];

  unidad_control_multiciclo #(.ANCHO_CONT(16), .MAX_ESPERA(8), .HABILITAR_ADDI(1)) dut_a (
    .clk(clk), .reset(rst_v[0]), .codigo_operacion(opc[0]), .mem_listo(listo_v[0]),
    .pc_escribir(pcw[0]), .pc_escribir_cond(pcwc[0]), .iord(iord_w[0]), .mem_leer(mlw[0]),
    .mem_escribir(mew[0]), .ir_escribir(irw[0]), .mem_a_reg(m2r[0]), .destino_reg(dst[0]),
    .reg_escribir(rgw[0]), .alu_fuente_a(afa[0]), .alu_fuente_b(afb[0]), .alu_operacion(aop[0]),
    .fuente_pc(fpc[0]), .estado(est[0]), .instr_terminada(ret[0]), .contador_instr(cnt_a),
    .op_invalida(opi[0]), .error_memoria(emem[0]));

  unidad_control_multiciclo #(.ANCHO_CONT(2), .MAX_ESPERA(4), .HABILITAR_ADDI(0)) dut_b (
    .clk(clk), .reset(rst_v[1]), .codigo_operacion(opc[1]), .mem_listo(listo_v[1]),
    .pc_escribir(pcw[1]), .pc_escribir_cond(pcwc[1]), .iord(iord_w[1]), .mem_leer(mlw[1]),
    .mem_escribir(mew[1]), .ir_escribir(irw[1]), .mem_a_reg(m2r[1]), .destino_reg(dst[1]),
    .reg_escribir(rgw[1]), .alu_fuente_a(afa[1]), .alu_fuente_b(afb[1]), .alu_operacion(aop[1]),
    .fuente_pc(fpc[1]), .estado(est[1]), .instr_terminada(ret[1]), .contador_instr(cnt_b),
    .op_invalida(opi[1]), .error_memoria(emem[1]));

  function automatic logic [16:0] obs_vec(input int d);
    return {pcw[d], pcwc[d], iord_w[d], mlw[d], mew[d], irw[d], m2r[d], dst[d], rgw[d],
            afa[d], afb[d], aop[d], fpc[d], ret[d]};
  endfunction

  function automatic logic [31:0] cnt_obs(input int d);
    return (d == 0) ? 32'(cnt_a) : 32'(cnt_b);
  endfunction

  // Expected datapath controls for a given step of an instruction
  function automatic logic [16:0] exp_vec(input logic [3:0] st, input logic listo);
    logic pw = 1'b0, pwc = 1'b0, io = 1'b0, ml = 1'b0, me = 1'b0, ir = 1'b0;
    logic mr = 1'b0, ds = 1'b0, rw = 1'b0, aa = 1'b0, rt = 1'b0;
    logic [1:0] ab = 2'b00, ao = 2'b00, fp = 2'b00;
    case (st)
      4'd0:  begin ml = 1'b1; ab = 2'b01; pw = listo; ir = listo; end
      4'd1:  ab = 2'b11;
      4'd2:  begin aa = 1'b1; ab = 2'b10; end
      4'd3:  begin ml = 1'b1; io = 1'b1; end
      4'd4:  begin rw = 1'b1; mr = 1'b1; rt = 1'b1; end
      4'd5:  begin me = 1'b1; io = 1'b1; rt = listo; end
      4'd6:  begin aa = 1'b1; ao = 2'b10; end
      4'd7:  begin rw = 1'b1; ds = 1'b1; rt = 1'b1; end
      4'd8:  begin aa = 1'b1; ao = 2'b01; pwc = 1'b1; fp = 2'b01; rt = 1'b1; end
      4'd9:  begin pw = 1'b1; fp = 2'b10; rt = 1'b1; end
      4'd10: begin aa = 1'b1; ab = 2'b10; end
      4'd11: begin rw = 1'b1; rt = 1'b1; end
      default: ;
    endcase
    return {pw, pwc, io, ml, me, ir, mr, ds, rw, aa, ab, ao, fp, rt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int d, input logic [3:0] st, input logic listo, input bit tmo);
    logic [16:0] e;
    @(negedge clk);
    opc[d] = next_op[d];
    listo_v[d] = listo;
    #1;
    e = exp_vec(st, listo);
    check("estado", 32'(est[d]), 32'(st));
    if (tmo) check("strobes_timeout", 32'(obs_vec(d) & MASK_STROBES), 32'd0);
    else     check("salidas", 32'(obs_vec(d)), 32'(e));
    check("contador_instr", cnt_obs(d), 32'(cnt_exp[d]));
    check("op_invalida", 32'(opi[d]), 32'(inv_exp[d]));
    check("error_memoria", 32'(emem[d]), 32'(err_exp[d]));
    if (!tmo && e[0] && cnt_exp[d] < (1 << ancho[d]) - 1) cnt_exp[d]++;
    if (tmo) err_exp[d] = 1'b1;
  endtask

  // A memory phase: `waits` not-ready cycles, aborted once the wait limit is hit
  task automatic mem_phase(input int d, input logic [3:0] st, input int waits, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= waits; k++) begin
      if (k == waits) begin
        step(d, st, 1'b1, 1'b0);
        ok = 1'b1;
        break;
      end else if (max_w[d] != 0 && k == max_w[d]) begin
        step(d, st, 1'b0, 1'b1);
        break;
      end else begin
        step(d, st, 1'b0, 1'b0);
      end
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input int d, input logic [5:0] op, input int wf, input int wm);
    bit ok;
    next_op[d] = op;
    mem_phase(d, 4'd0, wf, ok);
    if (!ok) return;
    step(d, 4'd1, rb(), 1'b0);
    case (op)
      6'b100011: begin
        step(d, 4'd2, rb(), 1'b0);
        mem_phase(d, 4'd3, wm, ok);
        if (ok) step(d, 4'd4, rb(), 1'b0);
      end
      6'b101011: begin
        step(d, 4'd2, rb(), 1'b0);
        mem_phase(d, 4'd5, wm, ok);
      end
      6'b000000: begin step(d, 4'd6, rb(), 1'b0); step(d, 4'd7, rb(), 1'b0); end
      6'b000100: step(d, 4'd8, rb(), 1'b0);
      6'b000010: step(d, 4'd9, rb(), 1'b0);
      6'b001000: begin
        if (addi_en[d]) begin
          step(d, 4'd10, rb(), 1'b0);
          step(d, 4'd11, rb(), 1'b0);
        end else begin
          inv_exp[d] = 1'b1;
        end
      end
      default: inv_exp[d] = 1'b1;
    endcase
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_v[d] = 1'b1;
    listo_v[d] = 1'b1;
    #1;
    cnt_exp[d] = 0;
    inv_exp[d] = 1'b0;
    err_exp[d] = 1'b0;
    check("reset_estado", 32'(est[d]), 32'd0);
    check("reset_strobes", 32'(obs_vec(d) & MASK_STROBES), 32'd0);
    check("reset_selects", 32'(obs_vec(d) & ~MASK_STROBES), 32'(exp_vec(4'd0, 1'b0) & ~MASK_STROBES));
    check("reset_contador", cnt_obs(d), 32'd0);
    check("reset_flags", 32'({opi[d], emem[d]}), 32'd0);
    @(posedge clk);
    #1;
    rst_v[d] = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    int k = $urandom_range(0, 6);
    return (k == 6) ? 6'($urandom_range(0, 63)) : ops[k];
  endfunction

  bit ok_v;

  initial begin
    rst_v = 2'b11;
    listo_v = 2'b00;
    opc[0] = 6'd0; opc[1] = 6'd0;
    next_op[0] = 6'd0; next_op[1] = 6'd0;

    // Configuration A: 16-bit counter, wait limit 8, ADDI enabled
    do_reset(0);
    run_instr(0, 6'b000000, 0, 0);
    run_instr(0, 6'b100011, 0, 2);
    run_instr(0, 6'b000100, 0, 0);
    run_instr(0, 6'b000010, 1, 0);
    run_instr(0, 6'b111111, 0, 0);
    run_instr(0, 6'b001000, 0, 0);
    run_instr(0, 6'b101011, 2, 3);
    for (int i = 0; i < 60; i++)
      run_instr(0, rand_op(), $urandom_range(0, 3), $urandom_range(0, 10));
    rst_v[0] = 1'b1;

    // Configuration B: 2-bit counter, wait limit 4, ADDI disabled
    do_reset(1);
    run_instr(1, 6'b001000, 0, 0);
    run_instr(1, 6'b000000, 0, 0);
    run_instr(1, 6'b101011, 0, 100);
    next_op[1] = 6'b101011;
    mem_phase(1, 4'd0, 0, ok_v);
    step(1, 4'd1, 1'b0, 1'b0);
    step(1, 4'd2, 1'b0, 1'b0);
    step(1, 4'd5, 1'b0, 1'b0);
    step(1, 4'd5, 1'b0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 5; i++) run_instr(1, 6'b000000, 0, 0);
    for (int i = 0; i < 30; i++)
      run_instr(1, rand_op(), $urandom_range(0, 2), $urandom_range(0, 6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
